// File: rtl/parking_pkg.sv
// Shared types and default timing for the parking lane controller.
// Holds the lane state encoding, badge class values and timing defaults.
package parking_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CHECK = 3'd1,
    OPEN  = 3'd2,
    CLOSE = 3'd3,
    CLEAR = 3'd4
  } lane_state_t;

  localparam logic CLASS_UNI   = 1'b1;
  localparam logic CLASS_OTHER = 1'b0;

  localparam int DEBOUNCE_DEF     = 4;
  localparam int OPEN_TIMEOUT_DEF = 1000;
  localparam int CLOSE_CYCLES_DEF = 50;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/parking_gate_ctrl_if.sv
// Event and vacancy link between the lane controller and the parking manager.
// Strobes are active-low and idle high; qualifiers are valid only while a strobe is low.
interface parking_gate_ctrl_if;

  logic car_entered;
  logic car_exited;
  logic is_uni_car_entered;
  logic is_uni_car_exited;
  logic uni_is_vacated_space;
  logic is_vacated_space;

  modport master (
    output car_entered,
    output car_exited,
    output is_uni_car_entered,
    output is_uni_car_exited,
    input  uni_is_vacated_space,
    input  is_vacated_space
  );

  modport slave (
    input  car_entered,
    input  car_exited,
    input  is_uni_car_entered,
    input  is_uni_car_exited,
    output uni_is_vacated_space,
    output is_vacated_space
  );

endinterface

// File: rtl/parking_debounce.sv
// Single-sensor debouncer: the level follows the raw input only after
// DEBOUNCE consecutive samples that disagree with the current level.
module parking_debounce #(
  parameter int DEBOUNCE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DEBOUNCE + 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt   <= '0;
      level <= 1'b0;
    end else if (raw == level) begin
      cnt <= '0;
    end else if (cnt == CW'(DEBOUNCE - 1)) begin
      level <= raw;
      cnt   <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/parking_lane_fsm.sv
// One lane's barrier sequencer (IDLE/CHECK/OPEN/CLOSE/CLEAR); IS_ENTRY enables
// the vacancy check and the denied pulse. event_fire marks a completed pass-through.
module parking_lane_fsm
  import parking_pkg::*;
#(
  parameter bit IS_ENTRY     = 1'b1,
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter int CLOSE_CYCLES = CLOSE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic loop_lvl,
  input  logic beam_lvl,
  input  logic badge_valid,
  input  logic badge_uni,
  input  logic vac_uni,
  input  logic vac_other,
  output logic barrier_open,
  output logic denied,
  output logic timeout,
  output logic event_fire,
  output logic event_uni
);

  localparam int TW = $clog2(max_int(OPEN_TIMEOUT, CLOSE_CYCLES) + 1);

  lane_state_t   state, state_nx;
  logic [TW-1:0] timer;
  logic          cls_q;
  logic          beam_q;
  logic          beam_rise;
  logic          vac_sel;
  logic          open_expire;
  logic          close_done;
  logic          barrier_d;
  logic          denied_d;
  logic          timeout_d;

  assign beam_rise   = beam_lvl & ~beam_q;
  assign vac_sel     = (cls_q == CLASS_UNI) ? vac_uni : vac_other;
  assign open_expire = (timer == TW'(OPEN_TIMEOUT - 1));
  assign close_done  = (timer == TW'(CLOSE_CYCLES - 1));
  assign event_uni   = cls_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      timer  <= '0;
      cls_q  <= CLASS_OTHER;
      beam_q <= 1'b0;
    end else begin
      state  <= state_nx;
      beam_q <= beam_lvl;
      // Timer restarts on every state change and only runs while OPEN or CLOSE.
      if ((state_nx == state) && ((state == OPEN) || (state == CLOSE)))
        timer <= timer + 1'b1;
      else
        timer <= '0;
      if ((state == IDLE) && (state_nx == CHECK))
        cls_q <= badge_uni;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (loop_lvl && badge_valid) state_nx = CHECK;
      CHECK:   state_nx = (!IS_ENTRY || vac_sel) ? OPEN : CLEAR;
      OPEN:    if (beam_rise || open_expire) state_nx = CLOSE;
      CLOSE:   if (close_done) state_nx = CLEAR;
      CLEAR:   if (!loop_lvl) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // A beam edge in the expiry cycle counts as a pass, so no timeout then.
  always_comb begin
    barrier_d  = (state_nx == OPEN);
    denied_d   = IS_ENTRY && (state == CHECK) && !vac_sel;
    timeout_d  = (state == OPEN) && !beam_rise && open_expire;
    event_fire = (state == OPEN) && beam_rise;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      barrier_open <= 1'b0;
      denied       <= 1'b0;
      timeout      <= 1'b0;
    end else begin
      barrier_open <= barrier_d;
      denied       <= denied_d;
      timeout      <= timeout_d;
    end
  end

endmodule

// File: rtl/parking_gate_ctrl.sv
// Entry/exit lane controller: debounces sensors, runs both lane sequencers and
// serialises pass-through events onto the manager's active-low strobes.
module parking_gate_ctrl
  import parking_pkg::*;
#(
  parameter int DEBOUNCE     = DEBOUNCE_DEF,
  parameter int OPEN_TIMEOUT = OPEN_TIMEOUT_DEF,
  parameter int CLOSE_CYCLES = CLOSE_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic entry_loop,
  input  logic exit_loop,
  input  logic entry_beam,
  input  logic exit_beam,
  input  logic entry_badge_valid,
  input  logic exit_badge_valid,
  input  logic entry_badge_uni,
  input  logic exit_badge_uni,
  output logic entry_barrier_open,
  output logic exit_barrier_open,
  output logic entry_denied,
  output logic entry_timeout,
  output logic exit_timeout,
  parking_gate_ctrl_if.master ev
);

  logic entry_loop_lvl, exit_loop_lvl, entry_beam_lvl, exit_beam_lvl;
  logic entry_fire, exit_fire, entry_uni, exit_uni;
  logic exit_denied_unused;
  logic pend_entry, pend_exit, cls_entry, cls_exit;

  parking_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_entry_loop (
    .clk(clk), .reset(reset), .raw(entry_loop), .level(entry_loop_lvl));
  parking_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_exit_loop (
    .clk(clk), .reset(reset), .raw(exit_loop), .level(exit_loop_lvl));
  parking_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_entry_beam (
    .clk(clk), .reset(reset), .raw(entry_beam), .level(entry_beam_lvl));
  parking_debounce #(.DEBOUNCE(DEBOUNCE)) u_db_exit_beam (
    .clk(clk), .reset(reset), .raw(exit_beam), .level(exit_beam_lvl));

  parking_lane_fsm #(
    .IS_ENTRY(1'b1), .OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_CYCLES(CLOSE_CYCLES)
  ) u_entry (
    .clk(clk), .reset(reset),
    .loop_lvl(entry_loop_lvl), .beam_lvl(entry_beam_lvl),
    .badge_valid(entry_badge_valid), .badge_uni(entry_badge_uni),
    .vac_uni(ev.uni_is_vacated_space), .vac_other(ev.is_vacated_space),
    .barrier_open(entry_barrier_open), .denied(entry_denied), .timeout(entry_timeout),
    .event_fire(entry_fire), .event_uni(entry_uni)
  );

  parking_lane_fsm #(
    .IS_ENTRY(1'b0), .OPEN_TIMEOUT(OPEN_TIMEOUT), .CLOSE_CYCLES(CLOSE_CYCLES)
  ) u_exit (
    .clk(clk), .reset(reset),
    .loop_lvl(exit_loop_lvl), .beam_lvl(exit_beam_lvl),
    .badge_valid(exit_badge_valid), .badge_uni(exit_badge_uni),
    .vac_uni(ev.uni_is_vacated_space), .vac_other(ev.is_vacated_space),
    .barrier_open(exit_barrier_open), .denied(exit_denied_unused), .timeout(exit_timeout),
    .event_fire(exit_fire), .event_uni(exit_uni)
  );

  // Exit drains first since it frees a space; a lane cannot re-fire before its
  // flag drains because it must pass through CLOSE and CLEAR first.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_entry            <= 1'b0;
      pend_exit             <= 1'b0;
      cls_entry             <= CLASS_OTHER;
      cls_exit              <= CLASS_OTHER;
      ev.car_entered        <= 1'b1;
      ev.car_exited         <= 1'b1;
      ev.is_uni_car_entered <= 1'b0;
      ev.is_uni_car_exited  <= 1'b0;
    end else begin
      ev.car_entered        <= 1'b1;
      ev.car_exited         <= 1'b1;
      ev.is_uni_car_entered <= 1'b0;
      ev.is_uni_car_exited  <= 1'b0;
      if (pend_exit) begin
        ev.car_exited        <= 1'b0;
        ev.is_uni_car_exited <= cls_exit;
        pend_exit            <= 1'b0;
      end else if (pend_entry) begin
        ev.car_entered        <= 1'b0;
        ev.is_uni_car_entered <= cls_entry;
        pend_entry            <= 1'b0;
      end
      if (exit_fire) begin
        pend_exit <= 1'b1;
        cls_exit  <= exit_uni;
      end
      if (entry_fire) begin
        pend_entry <= 1'b1;
        cls_entry  <= entry_uni;
      end
    end
  end

endmodule

// File: tb/tb_parking_gate_ctrl.sv
// Directed-plus-random bench for parking_gate_ctrl; expected strobes are derived
// from lane timing rules (raw beam rise + DEBOUNCE + 2, +1 when exit wins).
`timescale 1ns/1ps
module tb_parking_gate_ctrl;

  localparam int DB = 4;
  localparam int OT = 1000;
  localparam int CC = 50;

  typedef struct {
    int cyc;
    bit uni;
  } ev_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic loop_r [2];
  logic beam_r [2];
  logic bv_r   [2];
  logic bu_r   [2];
  logic entry_barrier_open, exit_barrier_open, entry_denied, entry_timeout, exit_timeout;
  logic [1:0] barrier;

  int cyc = 0;
  int n_tests = 0;
  int n_fail = 0;
  int mon_viol = 0;
  int done_ent = 0;
  int done_ext = 0;
  ev_t got_ent[$], got_ext[$], exp_ent[$], exp_ext[$];

  parking_gate_ctrl_if ev();

  parking_gate_ctrl #(.DEBOUNCE(DB), .OPEN_TIMEOUT(OT), .CLOSE_CYCLES(CC)) dut (
    .clk(clk), .reset(reset),
    .entry_loop(loop_r[0]), .exit_loop(loop_r[1]),
    .entry_beam(beam_r[0]), .exit_beam(beam_r[1]),
    .entry_badge_valid(bv_r[0]), .exit_badge_valid(bv_r[1]),
    .entry_badge_uni(bu_r[0]), .exit_badge_uni(bu_r[1]),
    .entry_barrier_open(entry_barrier_open), .exit_barrier_open(exit_barrier_open),
    .entry_denied(entry_denied), .entry_timeout(entry_timeout), .exit_timeout(exit_timeout),
    .ev(ev)
  );

  assign barrier = {exit_barrier_open, entry_barrier_open};

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Strobe recorder plus per-cycle invariants (one strobe at a time, qualifiers
  // idle at 0, no pending-flag overflow).
  always @(negedge clk) begin
    int v;
    v = 0;
    if (!reset) begin
      if (ev.car_entered === 1'b0) got_ent.push_back('{cyc, ev.is_uni_car_entered});
      if (ev.car_exited === 1'b0) got_ext.push_back('{cyc, ev.is_uni_car_exited});
      if (ev.car_entered === 1'b0 && ev.car_exited === 1'b0) v++;
      if (ev.car_entered !== 1'b0 && ev.is_uni_car_entered !== 1'b0) v++;
      if (ev.car_exited !== 1'b0 && ev.is_uni_car_exited !== 1'b0) v++;
      if ((dut.pend_entry && dut.entry_fire) || (dut.pend_exit && dut.exit_fire)) v++;
    end
    mon_viol <= mon_viol + v;
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  function automatic string tg(input int ln, input string s);
    return $sformatf("L%0d_%s", ln, s);
  endfunction

  task automatic expect_ev(input int ln, input int c, input bit u);
    if (ln == 0) exp_ent.push_back('{c, u});
    else exp_ext.push_back('{c, u});
  endtask

  task automatic set_vac(input bit u, input bit o);
    ev.uni_is_vacated_space = u;
    ev.is_vacated_space     = o;
  endtask

  task automatic cmp_events(input string tag);
    check({tag, "_n_entered"}, got_ent.size(), exp_ent.size());
    check({tag, "_n_exited"}, got_ext.size(), exp_ext.size());
    for (int i = done_ent; i < exp_ent.size() && i < got_ent.size(); i++) begin
      check($sformatf("%s_ent%0d_cyc", tag, i), got_ent[i].cyc, exp_ent[i].cyc);
      check($sformatf("%s_ent%0d_uni", tag, i), got_ent[i].uni, exp_ent[i].uni);
    end
    for (int i = done_ext; i < exp_ext.size() && i < got_ext.size(); i++) begin
      check($sformatf("%s_ext%0d_cyc", tag, i), got_ext[i].cyc, exp_ext[i].cyc);
      check($sformatf("%s_ext%0d_uni", tag, i), got_ext[i].uni, exp_ext[i].uni);
    end
    done_ent = exp_ent.size();
    done_ext = exp_ext.size();
    check({tag, "_invariants"}, mon_viol, 0);
  endtask

  // One vehicle on one lane: arm loop, badge, then pass (or be denied), then a
  // stray badge during CLOSE/CLEAR that must be ignored, then leave.
  task automatic pass_car(input int ln, input bit cls, input int gap);
    bit exp_open;
    int r0;
    logic seen;
    exp_open = (ln == 1) || (cls ? ev.uni_is_vacated_space : ev.is_vacated_space);
    loop_r[ln] = 1'b1;
    tick(DB);
    bv_r[ln] = 1'b1;
    bu_r[ln] = cls;
    tick();
    bv_r[ln] = 1'b0;
    check(tg(ln, "check_closed"), barrier[ln], 1'b0);
    tick();
    check(tg(ln, "open"), barrier[ln], exp_open);
    if (ln == 0) check(tg(ln, "denied"), entry_denied, !exp_open);
    set_vac(1'($urandom), 1'($urandom));
    if (exp_open) begin
      tick(gap);
      beam_r[ln] = 1'b1;
      r0 = cyc;
      expect_ev(ln, r0 + DB + 2, cls);
      tick(DB);
      check(tg(ln, "held_open"), barrier[ln], 1'b1);
      tick();
      check(tg(ln, "closed"), barrier[ln], 1'b0);
    end else begin
      tick();
      check(tg(ln, "denied_once"), entry_denied, 1'b0);
    end
    bv_r[ln] = 1'b1;
    bu_r[ln] = 1'($urandom);
    tick();
    bv_r[ln] = 1'b0;
    seen = 1'b0;
    repeat (CC + 6) begin
      tick();
      seen = seen | barrier[ln] | entry_denied | entry_timeout | exit_timeout;
    end
    check(tg(ln, "stray_badge_ignored"), seen, 1'b0);
    beam_r[ln] = 1'b0;
    loop_r[ln] = 1'b0;
    tick(DB + 2);
  endtask

  initial begin
    int r0, n;
    bit c0, c1;
    for (int i = 0; i < 2; i++) begin
      loop_r[i] = 1'b0; beam_r[i] = 1'b0; bv_r[i] = 1'b0; bu_r[i] = 1'b0;
    end
    set_vac(1'b0, 1'b0);

    // Reset state
    tick(3);
    check("rst_entry_barrier", entry_barrier_open, 1'b0);
    check("rst_exit_barrier", exit_barrier_open, 1'b0);
    check("rst_car_entered", ev.car_entered, 1'b1);
    check("rst_car_exited", ev.car_exited, 1'b1);
    check("rst_qualifiers", {ev.is_uni_car_entered, ev.is_uni_car_exited}, 2'b00);
    check("rst_pulses", {entry_denied, entry_timeout, exit_timeout}, 3'b000);
    reset = 1'b0;
    tick(2);

    // Directed: uni entry with space, other-class entry into a full lot, uni exit
    set_vac(1'b1, 1'b0);
    pass_car(0, 1'b1, 2);
    set_vac(1'b1, 1'b0);
    pass_car(0, 1'b0, 0);
    pass_car(1, 1'b1, 3);
    cmp_events("directed");

    // Random single-lane traffic
    repeat (6) begin
      set_vac(1'($urandom), 1'($urandom));
      pass_car(int'($urandom_range(0, 1)), 1'($urandom), int'($urandom_range(0, 6)));
    end
    cmp_events("random");

    // Timeout on the exit lane
    loop_r[1] = 1'b1;
    tick(DB);
    bv_r[1] = 1'b1; bu_r[1] = 1'($urandom);
    tick();
    bv_r[1] = 1'b0;
    tick();
    check("to_open", exit_barrier_open, 1'b1);
    tick(OT - 1);
    check("to_not_yet", exit_timeout, 1'b0);
    check("to_still_open", exit_barrier_open, 1'b1);
    tick();
    check("to_pulse", exit_timeout, 1'b1);
    check("to_closed", exit_barrier_open, 1'b0);
    tick();
    check("to_pulse_end", exit_timeout, 1'b0);
    tick(CC + 2);
    loop_r[1] = 1'b0;
    tick(DB + 2);
    cmp_events("timeout");

    // Collision: both debounced beam edges in the same cycle
    set_vac(1'b1, 1'b1);
    c0 = 1'($urandom);
    c1 = 1'($urandom);
    loop_r[0] = 1'b1; loop_r[1] = 1'b1;
    tick(DB);
    bv_r[0] = 1'b1; bv_r[1] = 1'b1; bu_r[0] = c0; bu_r[1] = c1;
    tick();
    bv_r[0] = 1'b0; bv_r[1] = 1'b0;
    tick();
    check("col_both_open", barrier, 2'b11);
    tick(int'($urandom_range(0, 5)));
    beam_r[0] = 1'b1; beam_r[1] = 1'b1;
    r0 = cyc;
    expect_ev(1, r0 + DB + 2, c1);
    expect_ev(0, r0 + DB + 3, c0);
    tick(DB + CC + 6);
    beam_r[0] = 1'b0; beam_r[1] = 1'b0; loop_r[0] = 1'b0; loop_r[1] = 1'b0;
    tick(DB + 2);
    cmp_events("collision");

    // Bounce rejection on the exit lane, then one genuine pulse
    c1 = 1'($urandom);
    loop_r[1] = 1'b1;
    tick(DB);
    bv_r[1] = 1'b1; bu_r[1] = c1;
    tick();
    bv_r[1] = 1'b0;
    tick();
    check("bnc_open", exit_barrier_open, 1'b1);
    n = int'($urandom_range(2, 4));
    repeat (n) begin
      beam_r[1] = 1'b1;
      tick(DB - 1);
      beam_r[1] = 1'b0;
      tick(DB - 1);
    end
    check("bnc_held_open", exit_barrier_open, 1'b1);
    cmp_events("bounce_reject");
    beam_r[1] = 1'b1;
    r0 = cyc;
    expect_ev(1, r0 + DB + 2, c1);
    tick(DB);
    beam_r[1] = 1'b0;
    tick();
    check("bnc_closed", exit_barrier_open, 1'b0);
    tick(CC + 4);
    loop_r[1] = 1'b0;
    tick(DB + 2);
    cmp_events("bounce_pass");

    // Reset with exit barrier open and an entry event pending
    set_vac(1'b1, 1'b1);
    loop_r[0] = 1'b1; loop_r[1] = 1'b1;
    tick(DB);
    bv_r[0] = 1'b1; bv_r[1] = 1'b1; bu_r[0] = 1'b1; bu_r[1] = 1'b0;
    tick();
    bv_r[0] = 1'b0; bv_r[1] = 1'b0;
    tick();
    check("rmid_both_open", barrier, 2'b11);
    beam_r[0] = 1'b1;
    tick(DB + 1);
    check("rmid_exit_open_pre", exit_barrier_open, 1'b1);
    reset = 1'b1;
    #1;
    check("rmid_async_barrier", barrier, 2'b00);
    loop_r[0] = 1'b0; loop_r[1] = 1'b0; beam_r[0] = 1'b0;
    tick(2);
    reset = 1'b0;
    tick(DB + 10);
    check("rmid_strobe_idle", {ev.car_entered, ev.car_exited}, 2'b11);
    cmp_events("reset_mid");
    loop_r[0] = 1'b1; loop_r[1] = 1'b1;
    tick(DB);
    bv_r[0] = 1'b1; bv_r[1] = 1'b1;
    tick();
    bv_r[0] = 1'b0; bv_r[1] = 1'b0;
    tick();
    check("rmid_idle_reopen", barrier, 2'b11);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
